button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Upstream input stage of the pet controller; sits between the board push-buttons/tilt sensor and the central state machine.
- Synchronises and debounces five active-low buttons and the tilt input; emits one-clock press pulses and a debounced tilt level.
- Owns test-mode entry and exit via a long press of the test button; in test mode it accumulates a 4-bit scenario selector that the central FSM consumes.

Parameters:
TICK_DIV, 50000, clk cycles per debounce tick (1 ms at 50 MHz); minimum 2
DEB_MS, 20, consecutive ticks of stable disagreement needed to accept a new level; minimum 1
LONG_MS, 2000, ticks the debounced test button must stay pressed to toggle test mode; must exceed DEB_MS

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
btn_sleep_n  input  1  raw sleep button, active-low, asynchronous
btn_awake_n  input  1  raw awake button, active-low, asynchronous
btn_feed_n  input  1  raw feed button, active-low, asynchronous
btn_play_n  input  1  raw play button, active-low, asynchronous
btn_test_n  input  1  raw test button, active-low, asynchronous
giro_raw  input  1  raw tilt sensor, active-high, asynchronous
sleep_pulse  output  1  one-cycle pulse on debounced sleep press
awake_pulse  output  1  one-cycle pulse on debounced awake press
feed_pulse  output  1  one-cycle pulse on debounced feed press
play_pulse  output  1  one-cycle pulse on debounced play press
giro_level  output  1  debounced tilt level
test_mode  output  1  level, high while test mode is active
test_count  output  4  test scenario selector

Behaviour:
- Reset (async) values: all pulses 0, giro_level 0, test_mode 0, test_count 0. Tick divider, all debounce counters and the test FSM clear. Every debounced button is stable "released".
- Synchroniser: each raw input passes through 2 flip-flops. Buttons are inverted to active-high after synchronisation.
- Tick generator: single-cycle tick every TICK_DIV clocks. The first tick occurs TICK_DIV cycles after reset release.
- Debounce, per input:
  - A counter increments on each tick while the synchronised value differs from the stable value.
  - The counter clears on any clock where the two agree.
  - When the counter reaches DEB_MS, the stable value takes the synchronised value and the counter clears.
  - Press-to-pulse latency: 2 clocks of sync, then between (DEB_MS-1)*TICK_DIV+1 and DEB_MS*TICK_DIV clocks, then 1 clock.
  - Bounces shorter than one tick are never seen.
- Pulse generation:
  - A button's pulse asserts for exactly one clk, on the cycle after its stable value goes 0->1.
  - No pulse on release. No repeat while held.
- Pulse gating: while test_mode=1, sleep_pulse, awake_pulse, feed_pulse and play_pulse are forced to 0, so pet stats are unaffected. The debounced events still drive test_count.
- Test FSM states:
  - OFF: enter OFF_HOLD when debounced test is pressed.
  - OFF_HOLD:
    - Hold counter increments per tick.
    - Release before LONG_MS returns to OFF with no effect.
    - At LONG_MS go to ON_WAIT: test_mode<=1 and test_count<=0 on the same edge.
  - ON_WAIT: stay until debounced test is released, then go to ON. This prevents re-toggling on a single hold.
  - ON:
    - Play press: test_count <= test_count+1, mod 16 (15 wraps to 0).
    - Sleep press: test_count <= test_count-1, mod 16 (0 wraps to 15).
    - Play and sleep presses in the same cycle: count unchanged.
    - Feed and awake presses are ignored.
    - Debounced test press goes to ON_HOLD.
  - ON_HOLD:
    - Release before LONG_MS returns to ON.
    - At LONG_MS: test_mode<=0 and go to OFF_WAIT.
    - test_count is held (not cleared) so the downstream FSM samples the selected scenario after test_mode falls.
  - OFF_WAIT: wait for release, then go to OFF.
- test_count changes only in ON, or on entry to test mode (cleared).
- Raw-button pulses arriving during ON_HOLD or ON_WAIT still update test_count as in ON.
- giro_level is debounced identically to the buttons; it is never gated and produces no pulse.
- Reset asserted mid-hold or mid-debounce returns everything to reset values immediately. A button still held at reset release must be re-debounced and produces a pulse.

Test Plan:
Use TICK_DIV=4, DEB_MS=3, LONG_MS=10.
- Press btn_feed_n low and hold 100 clk -> feed_pulse high for exactly 1 clk, 11–15 clk after press. No further pulse while held or on release.
- Toggle btn_play_n with 1–3 clk glitches for 40 clk, then hold stable low -> zero pulses during glitching. Exactly one play_pulse after the stable hold.
- Hold btn_test_n low for 60 clk (≥ DEB_MS+LONG_MS ticks) -> test_mode rises, test_count=0. Keep holding 100 more clk -> test_mode stays 1.
- In test mode: 3 play presses, then 1 sleep press, then 2 more sleep presses -> test_count 3, 2, 0. A further sleep press gives 15. A feed press in between leaves the count unchanged, and no feed_pulse appears.
- Long-press test again -> test_mode falls, test_count holds 15. A short test press (<LONG_MS) while in ON -> no change.
- Assert rst in the middle of OFF_HOLD with btn_test_n still low, then release rst -> all outputs 0. test_mode rises only after a full DEB_MS+LONG_MS ticks from reset release.

Source files
------------

// File: rtl/button_conditioner.sv
// Input stage for the pet controller: syncs and debounces five active-low buttons and the tilt
// sensor, emits one-clock press pulses, and runs the long-press test-mode selector.
module button_conditioner #(
   parameter int TICK_DIV = 50000,
   parameter int DEB_MS   = 20,
   parameter int LONG_MS  = 2000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_sleep_n,
   input  logic       btn_awake_n,
   input  logic       btn_feed_n,
   input  logic       btn_play_n,
   input  logic       btn_test_n,
   input  logic       giro_raw,
   output logic       sleep_pulse,
   output logic       awake_pulse,
   output logic       feed_pulse,
   output logic       play_pulse,
   output logic       giro_level,
   output logic       test_mode,
   output logic [3:0] test_count
);

   localparam int unsigned NIN = 6;
   localparam int unsigned SLEEP = 0;
   localparam int unsigned AWAKE = 1;
   localparam int unsigned FEED  = 2;
   localparam int unsigned PLAY  = 3;
   localparam int unsigned TEST  = 4;
   localparam int unsigned GIRO  = 5;

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int DW = (DEB_MS > 1) ? $clog2(DEB_MS + 1) : 1;
   localparam int HW = $clog2(LONG_MS + 1);

   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_MS - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_MS - 1);
   // Raw idle pattern: buttons high (released), tilt low.
   localparam logic [NIN-1:0] RAW_IDLE = 6'b011111;

   typedef enum logic [2:0] {
      OFF,
      OFF_HOLD,
      ON_WAIT,
      ON,
      ON_HOLD,
      OFF_WAIT
   } test_state_t;

   logic [TW-1:0]  tick_cnt;
   logic           tick;
   logic [NIN-1:0] raw, sync1, sync2, level, stable, stable_d, press;
   logic [DW-1:0]  deb_cnt [NIN];
   logic [3:0]     pulse_q;
   logic [HW-1:0]  hold_cnt;
   test_state_t    state;
   logic           test_mode_q;
   logic [3:0]     count_q;
   logic           test_dn;

   assign raw   = {giro_raw, btn_test_n, btn_play_n, btn_feed_n, btn_awake_n, btn_sleep_n};
   assign level = sync2 ^ RAW_IDLE;
   assign tick  = (tick_cnt == TICK_LAST);
   assign press = stable & ~stable_d;
   assign test_dn = stable[TEST];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1    <= RAW_IDLE;
         sync2    <= RAW_IDLE;
         stable   <= '0;
         stable_d <= '0;
         for (int unsigned i = 0; i < NIN; i++) deb_cnt[i] <= '0;
      end else begin
         sync1    <= raw;
         sync2    <= sync1;
         stable_d <= stable;
         for (int unsigned i = 0; i < NIN; i++) begin
            if (level[i] == stable[i]) begin
               deb_cnt[i] <= '0;
            end else if (tick) begin
               if (deb_cnt[i] == DEB_LAST) begin
                  stable[i]  <= level[i];
                  deb_cnt[i] <= '0;
               end else begin
                  deb_cnt[i] <= deb_cnt[i] + 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pulse_q <= '0;
      else     pulse_q <= press[3:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= OFF;
         hold_cnt    <= '0;
         test_mode_q <= 1'b0;
         count_q     <= '0;
      end else begin
         case (state)
            OFF: if (test_dn) begin
               state    <= OFF_HOLD;
               hold_cnt <= '0;
            end
            OFF_HOLD: begin
               if (!test_dn) begin
                  state <= OFF;
               end else if (tick) begin
                  if (hold_cnt == HOLD_LAST) begin
                     state       <= ON_WAIT;
                     test_mode_q <= 1'b1;
                     count_q     <= '0;
                  end else begin
                     hold_cnt <= hold_cnt + 1'b1;
                  end
               end
            end
            ON_WAIT: if (!test_dn) state <= ON;
            ON: if (test_dn) begin
               state    <= ON_HOLD;
               hold_cnt <= '0;
            end
            ON_HOLD: begin
               if (!test_dn) begin
                  state <= ON;
               end else if (tick) begin
                  if (hold_cnt == HOLD_LAST) begin
                     state       <= OFF_WAIT;
                     test_mode_q <= 1'b0;
                  end else begin
                     hold_cnt <= hold_cnt + 1'b1;
                  end
               end
            end
            OFF_WAIT: if (!test_dn) state <= OFF;
            default: state <= OFF;
         endcase

         // Selector keeps counting through the hold/wait states of test mode.
         if (state == ON || state == ON_WAIT || state == ON_HOLD) begin
            if (press[PLAY] && !press[SLEEP])      count_q <= count_q + 1'b1;
            else if (press[SLEEP] && !press[PLAY]) count_q <= count_q - 1'b1;
         end
      end
   end

   assign sleep_pulse = pulse_q[SLEEP] & ~test_mode_q;
   assign awake_pulse = pulse_q[AWAKE] & ~test_mode_q;
   assign feed_pulse  = pulse_q[FEED]  & ~test_mode_q;
   assign play_pulse  = pulse_q[PLAY]  & ~test_mode_q;
   assign giro_level  = stable[GIRO];
   assign test_mode   = test_mode_q;
   assign test_count  = count_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: expected pulses are queued with a latency window
// when a press is driven, and matched by a monitor as pulses appear.
module tb_button_conditioner;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_sleep_n = 1'b1;
   logic       btn_awake_n = 1'b1;
   logic       btn_feed_n  = 1'b1;
   logic       btn_play_n  = 1'b1;
   logic       btn_test_n  = 1'b1;
   logic       giro_raw    = 1'b0;
   logic       sleep_pulse, awake_pulse, feed_pulse, play_pulse;
   logic       giro_level, test_mode;
   logic [3:0] test_count;

   typedef struct {
      logic [3:0] code;
      int         lo;
      int         hi;
   } exp_t;

   exp_t sb[$];
   int   cyc   = 0;
   int   tests = 0;
   int   fails = 0;

   localparam logic [3:0] C_SLEEP = 4'b0001;
   localparam logic [3:0] C_AWAKE = 4'b0010;
   localparam logic [3:0] C_FEED  = 4'b0100;
   localparam logic [3:0] C_PLAY  = 4'b1000;

   button_conditioner #(.TICK_DIV(4), .DEB_MS(3), .LONG_MS(10)) dut (
      .clk(clk), .rst(rst),
      .btn_sleep_n(btn_sleep_n), .btn_awake_n(btn_awake_n), .btn_feed_n(btn_feed_n),
      .btn_play_n(btn_play_n), .btn_test_n(btn_test_n), .giro_raw(giro_raw),
      .sleep_pulse(sleep_pulse), .awake_pulse(awake_pulse), .feed_pulse(feed_pulse),
      .play_pulse(play_pulse), .giro_level(giro_level), .test_mode(test_mode),
      .test_count(test_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      logic [3:0] obs;
      exp_t       e;
      obs = {play_pulse, feed_pulse, awake_pulse, sleep_pulse};
      if (!rst && obs != 4'b0000) begin
         if (sb.size() == 0) begin
            check("unexpected_pulse", 32'(obs), 32'd0);
         end else begin
            e = sb.pop_front();
            check("pulse_code", 32'(obs), 32'(e.code));
            check("pulse_latency_ok", 32'(cyc >= e.lo && cyc <= e.hi), 32'd1);
         end
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_pulse(input logic [3:0] code);
      sb.push_back('{code: code, lo: cyc + 11, hi: cyc + 15});
   endtask

   // Press and release with enough time for both edges to debounce.
   task automatic tap(input logic [3:0] code);
      if (code[0]) btn_sleep_n = 1'b0;
      if (code[1]) btn_awake_n = 1'b0;
      if (code[2]) btn_feed_n  = 1'b0;
      if (code[3]) btn_play_n  = 1'b0;
      wait_clk(25);
      btn_sleep_n = 1'b1;
      btn_awake_n = 1'b1;
      btn_feed_n  = 1'b1;
      btn_play_n  = 1'b1;
      wait_clk(25);
   endtask

   initial begin
      int el, lo, hi;

      wait_clk(3);
      check("reset_outputs", 32'({sleep_pulse, awake_pulse, feed_pulse, play_pulse,
                                  giro_level, test_mode, test_count}), 32'd0);
      rst = 1'b0;
      wait_clk(20);
      check("idle_outputs", 32'({sleep_pulse, awake_pulse, feed_pulse, play_pulse,
                                 giro_level, test_mode, test_count}), 32'd0);

      // Feed held 100 clocks: one pulse 11-15 clocks after press, none on release.
      expect_pulse(C_FEED);
      btn_feed_n = 1'b0;
      wait_clk(100);
      check("feed_single_pulse", 32'(sb.size()), 32'd0);
      btn_feed_n = 1'b1;
      wait_clk(30);
      check("feed_no_release_pulse", 32'(sb.size()), 32'd0);

      // Play glitches of 1-3 clocks must be rejected, then a stable hold gives one pulse.
      el = 0;
      while (el < 40) begin
         lo = int'($urandom_range(1, 3));
         hi = int'($urandom_range(1, 3));
         btn_play_n = 1'b0;
         wait_clk(lo);
         btn_play_n = 1'b1;
         wait_clk(hi);
         el += lo + hi;
      end
      wait_clk(4);
      expect_pulse(C_PLAY);
      btn_play_n = 1'b0;
      wait_clk(60);
      check("play_after_glitch", 32'(sb.size()), 32'd0);
      btn_play_n = 1'b1;
      wait_clk(30);

      expect_pulse(C_SLEEP);
      tap(C_SLEEP);
      check("sleep_pulse_seen", 32'(sb.size()), 32'd0);
      expect_pulse(C_AWAKE);
      tap(C_AWAKE);
      check("awake_pulse_seen", 32'(sb.size()), 32'd0);

      giro_raw = 1'b1;
      wait_clk(20);
      check("giro_rise", 32'(giro_level), 32'd1);

      // Long press of test enters test mode with a cleared selector.
      btn_test_n = 1'b0;
      wait_clk(45);
      check("test_mode_not_yet", 32'(test_mode), 32'd0);
      wait_clk(15);
      check("test_mode_enter", 32'(test_mode), 32'd1);
      check("test_count_cleared", 32'(test_count), 32'd0);
      wait_clk(100);
      check("test_mode_hold_stays", 32'(test_mode), 32'd1);
      btn_test_n = 1'b1;
      wait_clk(30);
      check("test_mode_after_release", 32'(test_mode), 32'd1);

      tap(C_PLAY);
      check("count_play1", 32'(test_count), 32'd1);
      tap(C_PLAY);
      check("count_play2", 32'(test_count), 32'd2);
      tap(C_PLAY);
      check("count_play3", 32'(test_count), 32'd3);
      tap(C_FEED);
      check("count_feed_ignored", 32'(test_count), 32'd3);
      tap(C_SLEEP);
      check("count_sleep1", 32'(test_count), 32'd2);
      tap(C_SLEEP);
      check("count_sleep2", 32'(test_count), 32'd1);
      tap(C_SLEEP);
      check("count_sleep3", 32'(test_count), 32'd0);
      tap(C_SLEEP);
      check("count_wrap_down", 32'(test_count), 32'd15);
      tap(C_PLAY | C_SLEEP);
      check("count_play_sleep_same", 32'(test_count), 32'd15);

      giro_raw = 1'b0;
      wait_clk(20);
      check("giro_fall_in_test", 32'(giro_level), 32'd0);

      // Short test press in test mode changes nothing.
      btn_test_n = 1'b0;
      wait_clk(25);
      btn_test_n = 1'b1;
      wait_clk(30);
      check("short_press_mode", 32'(test_mode), 32'd1);
      check("short_press_count", 32'(test_count), 32'd15);

      // Long press leaves test mode, selector held.
      btn_test_n = 1'b0;
      wait_clk(60);
      check("test_mode_exit", 32'(test_mode), 32'd0);
      check("count_held_on_exit", 32'(test_count), 32'd15);
      btn_test_n = 1'b1;
      wait_clk(30);
      check("count_held_after_release", 32'(test_count), 32'd15);
      expect_pulse(C_FEED);
      tap(C_FEED);
      check("feed_after_exit", 32'(sb.size()), 32'd0);

      // Reset in the middle of OFF_HOLD and mid feed debounce, both inputs kept low.
      btn_test_n = 1'b0;
      wait_clk(25);
      btn_feed_n = 1'b0;
      wait_clk(5);
      rst = 1'b1;
      wait_clk(1);
      check("reset_mid_hold_outputs", 32'({sleep_pulse, awake_pulse, feed_pulse, play_pulse,
                                           giro_level, test_mode, test_count}), 32'd0);
      wait_clk(3);
      rst = 1'b0;
      expect_pulse(C_FEED);
      wait_clk(1);
      check("after_reset_outputs", 32'({sleep_pulse, awake_pulse, feed_pulse, play_pulse,
                                        giro_level, test_mode, test_count}), 32'd0);
      wait_clk(44);
      check("reset_rehold_not_yet", 32'(test_mode), 32'd0);
      wait_clk(15);
      check("reset_rehold_enter", 32'(test_mode), 32'd1);
      check("reset_rehold_count", 32'(test_count), 32'd0);
      btn_test_n = 1'b1;
      btn_feed_n = 1'b1;
      wait_clk(30);
      check("feed_redebounced_after_reset", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
